// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_defs: shared state codes, instruction fields and datapath select encodings
package mc_defs;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DID = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BEQ  = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    typedef struct packed {
        logic is_r_alu;
        logic is_ori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_bad;
    } ins_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// mc_decode: op/funct to one-hot instruction class, plus add/sub selector for R-type ALU ops
module mc_decode
    import mc_defs::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output ins_class_t      cls,
    output logic            r_sub
);

    logic rtype;

    // classify the instruction; anything not recognised is flagged bad
    always_comb begin
        rtype        = op == OP_RTYPE;
        cls.is_r_alu = rtype && (funct == FN_ADDU || funct == FN_SUBU);
        cls.is_jr    = rtype && funct == FN_JR;
        cls.is_ori   = op == OP_ORI;
        cls.is_lui   = op == OP_LUI;
        cls.is_lw    = op == OP_LW;
        cls.is_sw    = op == OP_SW;
        cls.is_beq   = op == OP_BEQ;
        cls.is_j     = op == OP_J;
        cls.is_jal   = op == OP_JAL;
        cls.is_bad   = !(cls.is_r_alu || cls.is_jr || cls.is_ori || cls.is_lui || cls.is_lw ||
                         cls.is_sw || cls.is_beq || cls.is_j || cls.is_jal);
        r_sub        = funct == FN_SUBU;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM sequencing IF/DID/EXE/MEM/WB and driving datapath selects
module mc_ctrl_fsm
    import mc_defs::*;
#(
    parameter int ST_W = 3,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output logic            pc_we,
    output logic            ir_we,
    output logic [1:0]      npc_sel,
    output logic            rf_we,
    output logic            dm_we,
    output logic [1:0]      reg_dst,
    output logic [1:0]      wd_sel,
    output logic            alu_src_b,
    output logic [1:0]      ext_op,
    output logic [1:0]      alu_op,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    state_t     state_q;
    state_t     state_d;
    ins_class_t cls;
    logic       r_sub;

    mc_decode #(.OP_W(OP_W)) u_decode (
        .op    (op),
        .funct (funct),
        .cls   (cls),
        .r_sub (r_sub)
    );

    assign state = ST_W'(state_q);

    // state register; reset returns to fetch and abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    // next-state: instruction class decides how far down the IF..WB chain it travels
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_DID;
            S_DID: state_d = (cls.is_j || cls.is_jal || cls.is_jr || cls.is_bad) ? S_IF : S_EXE;
            S_EXE: state_d = (cls.is_lw || cls.is_sw) ? S_MEM :
                             (cls.is_r_alu || cls.is_ori || cls.is_lui) ? S_WB : S_IF;
            S_MEM: state_d = cls.is_lw ? S_WB : S_IF;
            default: state_d = S_IF;
        endcase
    end

    // per-state datapath controls; everything held at 0 while reset is asserted
    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        npc_sel   = NPC_PC4;
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        alu_src_b = 1'b0;
        ext_op    = EXT_ZERO;
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
        if (rst) begin
            case (state_q)
                S_IF: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                S_DID: begin
                    pc_we   = cls.is_j || cls.is_jal || cls.is_jr;
                    npc_sel = cls.is_jr ? NPC_JR : (cls.is_j || cls.is_jal) ? NPC_J : NPC_PC4;
                    rf_we   = cls.is_jal;
                    reg_dst = cls.is_jal ? DST_RA : DST_RT;
                    wd_sel  = cls.is_jal ? WD_PC4 : WD_ALU;
                    illegal = cls.is_bad;
                end
                S_EXE: begin
                    alu_src_b = cls.is_ori || cls.is_lui || cls.is_lw || cls.is_sw;
                    ext_op    = cls.is_lui ? EXT_LUI :
                                (cls.is_lw || cls.is_sw || cls.is_beq) ? EXT_SIGN : EXT_ZERO;
                    alu_op    = cls.is_ori ? ALU_OR :
                                (cls.is_beq || (cls.is_r_alu && r_sub)) ? ALU_SUB : ALU_ADD;
                    pc_we     = cls.is_beq;
                    npc_sel   = cls.is_beq ? NPC_BEQ : NPC_PC4;
                end
                S_MEM: begin
                    alu_src_b = 1'b1;
                    ext_op    = EXT_SIGN;
                    dm_we     = cls.is_sw;
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    reg_dst = cls.is_r_alu ? DST_RD : DST_RT;
                    wd_sel  = cls.is_lw ? WD_DM : WD_ALU;
                end
                default: ;
            endcase
        end
    end

endmodule
